nes_controller_if: RTL and testbench

- Controller-port front end for the CPU memory map's $4016/$4017 joypad interface.
- Sits upstream of cpu_memory and drives its ctlr_data_p1/ctlr_data_p2 inputs, replacing the constant-1 tie-off.
- Consumes cpu_memory's ctlr_latch, ctlr_pulse_p1 and ctlr_pulse_p2.
- Synchronises and debounces raw board button pins, then emulates the 4021 parallel-in/serial-out shifter of a standard NES pad, one per port.

---
 rtl/ctlr_pkg.sv | 33 +++
 rtl/ctlr_debounce.sv | 46 ++++
 rtl/ctlr_shifter.sv | 33 +++
 rtl/nes_controller_if.sv | 84 ++++++++
 tb/tb_nes_controller_if.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ctlr_pkg.sv
// Shared definitions for the NES joypad front end: button indices, bus width
// and the opposing-direction mask.
package ctlr_pkg;

    localparam int unsigned CTLR_BITS = 8;

    typedef enum logic [2:0] {
        BTN_A      = 3'd0,
        BTN_B      = 3'd1,
        BTN_SELECT = 3'd2,
        BTN_START  = 3'd3,
        BTN_UP     = 3'd4,
        BTN_DOWN   = 3'd5,
        BTN_LEFT   = 3'd6,
        BTN_RIGHT  = 3'd7
    } btn_e;

    // A pad cannot physically report both directions of one axis; drop both.
    function automatic logic [CTLR_BITS-1:0] block_opposing(input logic [CTLR_BITS-1:0] btn);
        logic [CTLR_BITS-1:0] res;
        res = btn;
        if (btn[BTN_UP] && btn[BTN_DOWN]) begin
            res[BTN_UP]   = 1'b0;
            res[BTN_DOWN] = 1'b0;
        end
        if (btn[BTN_LEFT] && btn[BTN_RIGHT]) begin
            res[BTN_LEFT]  = 1'b0;
            res[BTN_RIGHT] = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/ctlr_debounce.sv
// One button pin: 2-flop synchroniser, active-high conversion and a
// consecutive-cycle debounce counter driving the stable state.
module ctlr_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pin_n,
    output logic stable
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_n;
    logic             sync2_n;
    logic             synced;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_n <= 1'b1;
            sync2_n <= 1'b1;
        end else begin
            sync1_n <= pin_n;
            sync2_n <= sync1_n;
        end
    end

    assign synced = ~sync2_n;

    // Any agreement with the stable state restarts the count, so glitches never land.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (synced == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= ~stable;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ctlr_shifter.sv
// 4021-style parallel-in/serial-out shifter for one pad port.
module ctlr_shifter
    import ctlr_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 latch,
    input  logic                 pulse,
    input  logic [CTLR_BITS-1:0] pressed,
    output logic                 data
);

    logic                 pulse_q;
    logic [CTLR_BITS-1:0] sr;

    // Latch level reloads every cycle and overrides any clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pulse_q <= 1'b0;
            sr      <= {CTLR_BITS{1'b1}};
        end else begin
            pulse_q <= pulse;
            if (latch) begin
                sr <= ~pressed;
            end else if (pulse && !pulse_q) begin
                sr <= {1'b0, sr[CTLR_BITS-1:1]};
            end
        end
    end

    assign data = sr[0];

endmodule

// File: rtl/nes_controller_if.sv
// Joypad front end for $4016/$4017: debounces both ports' pins, masks
// opposing directions and serialises each port like an official pad.
module nes_controller_if
    import ctlr_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          BLOCK_OPPOSING  = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [CTLR_BITS-1:0] btn_p1_n,
    input  logic [CTLR_BITS-1:0] btn_p2_n,
    input  logic                 ctlr_latch,
    input  logic                 ctlr_pulse_p1,
    input  logic                 ctlr_pulse_p2,
    output logic                 ctlr_data_p1,
    output logic                 ctlr_data_p2,
    output logic [CTLR_BITS-1:0] pressed_p1,
    output logic [CTLR_BITS-1:0] pressed_p2
);

    logic [CTLR_BITS-1:0] stable_p1;
    logic [CTLR_BITS-1:0] stable_p2;
    logic [CTLR_BITS-1:0] masked_p1;
    logic [CTLR_BITS-1:0] masked_p2;

    for (genvar i = 0; i < CTLR_BITS; i++) begin : g_btn
        ctlr_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db_p1 (
            .clock  (clock),
            .reset_n(reset_n),
            .pin_n  (btn_p1_n[i]),
            .stable (stable_p1[i])
        );

        ctlr_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db_p2 (
            .clock  (clock),
            .reset_n(reset_n),
            .pin_n  (btn_p2_n[i]),
            .stable (stable_p2[i])
        );
    end

    always_comb begin
        masked_p1 = stable_p1;
        masked_p2 = stable_p2;
        if (BLOCK_OPPOSING) begin
            masked_p1 = block_opposing(stable_p1);
            masked_p2 = block_opposing(stable_p2);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pressed_p1 <= '0;
            pressed_p2 <= '0;
        end else begin
            pressed_p1 <= masked_p1;
            pressed_p2 <= masked_p2;
        end
    end

    ctlr_shifter u_sh_p1 (
        .clock  (clock),
        .reset_n(reset_n),
        .latch  (ctlr_latch),
        .pulse  (ctlr_pulse_p1),
        .pressed(pressed_p1),
        .data   (ctlr_data_p1)
    );

    ctlr_shifter u_sh_p2 (
        .clock  (clock),
        .reset_n(reset_n),
        .latch  (ctlr_latch),
        .pulse  (ctlr_pulse_p2),
        .pressed(pressed_p2),
        .data   (ctlr_data_p2)
    );

endmodule

// File: tb/tb_nes_controller_if.sv
// Bench for nes_controller_if: directed scenarios plus random traffic against a
// window-based debounce model and a scan-position pad model.
module tb_nes_controller_if;

    localparam int DC = 4;

    logic       clock;
    logic       reset_n;
    logic [7:0] btn_p1_n;
    logic [7:0] btn_p2_n;
    logic       ctlr_latch;
    logic       ctlr_pulse_p1;
    logic       ctlr_pulse_p2;
    logic       ctlr_data_p1;
    logic       ctlr_data_p2;
    logic [7:0] pressed_p1;
    logic [7:0] pressed_p2;

    int checks = 0;
    int errors = 0;

    nes_controller_if #(
        .DEBOUNCE_CYCLES(DC),
        .BLOCK_OPPOSING (1'b1)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .btn_p1_n     (btn_p1_n),
        .btn_p2_n     (btn_p2_n),
        .ctlr_latch   (ctlr_latch),
        .ctlr_pulse_p1(ctlr_pulse_p1),
        .ctlr_pulse_p2(ctlr_pulse_p2),
        .ctlr_data_p1 (ctlr_data_p1),
        .ctlr_data_p2 (ctlr_data_p2),
        .pressed_p1   (pressed_p1),
        .pressed_p2   (pressed_p2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: pins seen two edges late, stable flips once the last DC
    // synced samples all disagree with it; each pad is a captured byte plus a
    // read position.
    logic [15:0] pin_q[$];
    logic [15:0] sync_q[$];
    logic [15:0] m_stable;
    logic [15:0] m_pressed;
    logic [7:0]  m_cap[2];
    int          m_pos[2];
    logic        m_prev[2];

    function automatic logic [7:0] mask8(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b[4] && b[5]) r[5:4] = 2'b00;
        if (b[6] && b[7]) r[7:6] = 2'b00;
        return r;
    endfunction

    function automatic logic exp_data(input int p);
        if (m_pos[p] >= 8) return 1'b0;
        return ~m_cap[p][m_pos[p]];
    endfunction

    task automatic model_reset();
        pin_q = '{16'h0000, 16'h0000};
        sync_q.delete();
        m_stable  = 16'h0000;
        m_pressed = 16'h0000;
        for (int p = 0; p < 2; p++) begin
            m_cap[p]  = 8'h00;
            m_pos[p]  = 0;
            m_prev[p] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [15:0] pins;
        logic [15:0] synced;
        logic [15:0] old_stable;
        logic [15:0] old_pressed;
        logic        pulses[2];
        logic        all_diff;
        pins   = ~{btn_p2_n, btn_p1_n};
        synced = pin_q[0];
        void'(pin_q.pop_front());
        pin_q.push_back(pins);
        sync_q.push_back(synced);
        if (sync_q.size() > DC) void'(sync_q.pop_front());
        old_stable  = m_stable;
        old_pressed = m_pressed;
        if (sync_q.size() == DC) begin
            for (int b = 0; b < 16; b++) begin
                all_diff = 1'b1;
                foreach (sync_q[k]) if (sync_q[k][b] == old_stable[b]) all_diff = 1'b0;
                if (all_diff) m_stable[b] = ~old_stable[b];
            end
        end
        m_pressed = {mask8(old_stable[15:8]), mask8(old_stable[7:0])};
        pulses[0] = ctlr_pulse_p1;
        pulses[1] = ctlr_pulse_p2;
        for (int p = 0; p < 2; p++) begin
            if (ctlr_latch) begin
                m_cap[p] = (p == 0) ? old_pressed[7:0] : old_pressed[15:8];
                m_pos[p] = 0;
            end else if (pulses[p] && !m_prev[p] && m_pos[p] < 8) begin
                m_pos[p] = m_pos[p] + 1;
            end
            m_prev[p] = pulses[p];
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (!reset_n) model_reset();
        else model_edge();
        #1;
        chk("data_p1", {7'b0, ctlr_data_p1}, {7'b0, exp_data(0)});
        chk("data_p2", {7'b0, ctlr_data_p2}, {7'b0, exp_data(1)});
        chk("pressed_p1", pressed_p1, m_pressed[7:0]);
        chk("pressed_p2", pressed_p2, m_pressed[15:8]);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse1(input string tag, input logic exp);
        chk(tag, {7'b0, ctlr_data_p1}, {7'b0, exp});
        ctlr_pulse_p1 = 1'b1;
        step();
        ctlr_pulse_p1 = 1'b0;
        step();
    endtask

    task automatic latch_scan();
        ctlr_latch = 1'b1;
        steps(2);
        ctlr_latch = 1'b0;
        steps(1);
    endtask

    logic [7:0] scan_seq;
    logic [7:0] a_seq;

    initial begin
        btn_p1_n      = 8'hFF;
        btn_p2_n      = 8'hFF;
        ctlr_latch    = 1'b0;
        ctlr_pulse_p1 = 1'b0;
        ctlr_pulse_p2 = 1'b0;
        reset_n       = 1'b1;
        model_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_data_p1", {7'b0, ctlr_data_p1}, 8'h01);
        chk("rst_data_p2", {7'b0, ctlr_data_p2}, 8'h01);
        chk("rst_pressed_p1", pressed_p1, 8'h00);
        chk("rst_pressed_p2", pressed_p2, 8'h00);
        steps(2);
        reset_n = 1'b1;
        steps(3);

        // A + Start scan: bits read LSB first, then zeros after the eighth
        btn_p1_n = 8'hF6;
        steps(10);
        chk("scan_pressed", pressed_p1, 8'h09);
        latch_scan();
        scan_seq = 8'b1111_0110;
        for (int i = 0; i < 8; i++) pulse1("scan_bit", scan_seq[i]);
        for (int i = 0; i < 4; i++) pulse1("scan_tail", 1'b0);

        // Debounce: 3-cycle glitch is rejected, a held press lands on cycle 7
        btn_p2_n = 8'hFD;
        steps(3);
        btn_p2_n = 8'hFF;
        steps(8);
        chk("glitch_p2", pressed_p2, 8'h00);
        btn_p2_n = 8'hFD;
        steps(6);
        chk("db_early_p2", pressed_p2, 8'h00);
        steps(1);
        chk("db_land_p2", pressed_p2, 8'h02);
        btn_p2_n = 8'hFF;
        steps(8);

        // Opposing directions
        btn_p1_n = 8'h8F;
        steps(8);
        chk("opp_udl", pressed_p1, 8'h40);
        btn_p1_n = 8'hAF;
        steps(8);
        chk("opp_ul", pressed_p1, 8'h50);

        // Pulses while latched never advance the shifter
        btn_p1_n = 8'hFE;
        steps(8);
        ctlr_latch = 1'b1;
        steps(2);
        for (int i = 0; i < 5; i++) begin
            ctlr_pulse_p1 = 1'b1;
            step();
            chk("latched_hi", {7'b0, ctlr_data_p1}, 8'h00);
            ctlr_pulse_p1 = 1'b0;
            step();
            chk("latched_lo", {7'b0, ctlr_data_p1}, 8'h00);
        end
        ctlr_latch = 1'b0;
        steps(1);
        chk("latch_fall", {7'b0, ctlr_data_p1}, 8'h00);

        // Reset mid-scan, then a full re-scan
        latch_scan();
        a_seq = 8'b1111_1110;
        for (int i = 0; i < 3; i++) pulse1("pre_rst_bit", a_seq[i]);
        reset_n = 1'b0;
        #1;
        chk("midrst_data_p1", {7'b0, ctlr_data_p1}, 8'h01);
        chk("midrst_pressed_p1", pressed_p1, 8'h00);
        model_reset();
        steps(2);
        reset_n = 1'b1;
        steps(8);
        chk("post_rst_pressed", pressed_p1, 8'h01);
        latch_scan();
        for (int i = 0; i < 8; i++) pulse1("post_rst_bit", a_seq[i]);

        // Random traffic on both ports
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) btn_p1_n = 8'($urandom);
            if ($urandom_range(0, 7) == 0) btn_p2_n = 8'($urandom);
            ctlr_latch    = ($urandom_range(0, 11) == 0);
            ctlr_pulse_p1 = ($urandom_range(0, 2) == 0);
            ctlr_pulse_p2 = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
